// File: rtl/board_generator.sv
// Builds a random solution board with an exact number of lit tiles, seeded by a
// free-running 16-bit Fibonacci LFSR, one new tile per cycle after a start edge.
module board_generator #(
  parameter int unsigned TILES = 8,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       num_tiles,
  output logic [TILES-1:0] board,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, CLEAR, FILL, DONE} state_t;

  localparam int unsigned IDX_W   = (TILES > 1) ? $clog2(TILES) : 1;
  localparam logic [3:0]  TILES_4 = 4'(TILES);

  state_t           state, state_next;
  logic [15:0]      lfsr;
  logic             lfsr_fb;
  logic             start_q;
  logic             start_edge;
  logic [3:0]       count;
  logic [3:0]       target;
  logic [3:0]       target_clamped;
  logic [TILES-1:0] fill_mask;

  assign start_edge = start & ~start_q;
  // Taps 16,14,13,11 expressed on a right-shifting register.
  assign lfsr_fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_comb begin
    target_clamped = num_tiles;
    if (num_tiles == 4'd0)
      target_clamped = 4'd1;
    else if (num_tiles > TILES_4)
      target_clamped = TILES_4;
  end

  // One-hot mask of the first clear tile at or above lfsr[2:0], wrapping.
  always_comb begin
    int unsigned      p;
    logic             found;
    logic [IDX_W-1:0] idx;
    fill_mask = '0;
    found     = 1'b0;
    idx       = '0;
    p         = 32'(lfsr[2:0]) % TILES;
    for (int unsigned i = 0; i < TILES; i++) begin
      idx = IDX_W'((p + i) % TILES);
      if (!found && !board[idx]) begin
        fill_mask[idx] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE:  if (start_edge) state_next = CLEAR;
      CLEAR: begin
        busy       = 1'b1;
        state_next = FILL;
      end
      FILL: begin
        busy = 1'b1;
        if (count + 4'd1 == target) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      lfsr    <= SEED;
      start_q <= 1'b0;
      board   <= '0;
      count   <= 4'd0;
      target  <= 4'd1;
    end else begin
      state   <= state_next;
      lfsr    <= {lfsr_fb, lfsr[15:1]};
      start_q <= start;
      unique case (state)
        IDLE:  if (start_edge) target <= target_clamped;
        CLEAR: begin
          board <= '0;
          count <= 4'd0;
        end
        FILL: begin
          board <= board | fill_mask;
          count <= count + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_generator.sv
// Self-checking bench for board_generator: randomized builds compared against an
// arithmetic model of the tile-selection rule driven by a reference LFSR.
module tb_board_generator;

  localparam int          TILES = 8;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [3:0]       num_tiles;
  logic [TILES-1:0] board;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  board_generator #(.TILES(TILES), .SEED(SEED)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_tiles (num_tiles),
    .board     (board),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference LFSR: polynomial x^16+x^14+x^13+x^11+1, new bit enters at the top.
  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    int   taps [4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (taps[k]) fb = fb ^ x[16 - taps[k]];
    return {fb, x[15:1]};
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr = SEED;
    else        m_lfsr = lfsr_step(m_lfsr);
  end

  function automatic int clamp(input logic [3:0] nt);
    if (nt == 0) return 1;
    if (int'(nt) > TILES) return TILES;
    return int'(nt);
  endfunction

  // l is the LFSR value in the cycle start is raised; the first placement uses
  // the value two cycles later, then one new LFSR value per placed tile.
  function automatic logic [TILES-1:0] predict(input logic [15:0] l, input int tgt);
    logic [TILES-1:0] b = '0;
    logic [15:0]      x = lfsr_step(lfsr_step(l));
    int               p;
    for (int k = 0; k < tgt; k++) begin
      p = int'(x[2:0]) % TILES;
      for (int j = 0; j < TILES; j++) begin
        if (!b[(p + j) % TILES]) begin
          b[(p + j) % TILES] = 1'b1;
          break;
        end
      end
      x = lfsr_step(x);
    end
    return b;
  endfunction

  // Entered just after a posedge; returns just after a posedge.
  task automatic run_build(input logic [3:0] nt, input int hold, input bit poke,
                           input string name);
    int               tgt       = clamp(nt);
    logic [TILES-1:0] exp_board = predict(m_lfsr, tgt);
    int               done_cnt  = 0;
    int               done_at   = -1;
    int               busy_cnt  = 0;
    bit               stable    = 1'b1;
    int               last      = ((hold > tgt + 2) ? hold : tgt + 2) + 4;
    num_tiles = nt;
    start     = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      if (c >= hold) start = 1'b0;
      if (poke && c == 3) begin
        start     = 1'b1;
        num_tiles = 4'($urandom_range(0, 15));
      end
      if (poke && c == 4) start = 1'b0;
      @(negedge clk);
      if (done) begin
        done_cnt++;
        done_at = c;
      end
      if (busy) busy_cnt++;
      if (done_at >= 0 && c > done_at && board !== exp_board) stable = 1'b0;
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL %s done_count: got %0d want 1", name, done_cnt);
    end
    n_checks++;
    if (done_at != tgt + 2) begin
      n_fail++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, done_at, tgt + 2);
    end
    n_checks++;
    if (busy_cnt != tgt + 1) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, tgt + 1);
    end
    n_checks++;
    if (board !== exp_board) begin
      n_fail++;
      $display("FAIL %s board: got %h want %h", name, board, exp_board);
    end
    n_checks++;
    if ($countones(board) != tgt) begin
      n_fail++;
      $display("FAIL %s popcount: got %0d want %0d", name, $countones(board), tgt);
    end
    n_checks++;
    if (!stable) begin
      n_fail++;
      $display("FAIL %s board_stable: got changed want held %h", name, exp_board);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    start     = 1'b0;
    num_tiles = 4'd0;
    #12;
    n_checks++;
    if ({board, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got board=%h busy=%b done=%b want 0/0/0", board, busy, done);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({board, busy, done} !== '0) begin
        n_fail++;
        $display("FAIL idle_hold: got board=%h busy=%b done=%b want 0/0/0", board, busy, done);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_boundaries();
    run_build(4'd3,  1, 1'b0, "nt3");
    run_build(4'd0,  1, 1'b0, "nt0");
    run_build(4'd12, 1, 1'b0, "nt12");
    n_checks++;
    if (board !== 8'hFF) begin
      n_fail++;
      $display("FAIL nt12_full: got %h want ff", board);
    end
    run_build(4'd8,  1, 1'b0, "nt8");
    n_checks++;
    if (board !== 8'hFF) begin
      n_fail++;
      $display("FAIL nt8_full: got %h want ff", board);
    end
  endtask

  task automatic test_ignore_start();
    run_build(4'd5, 1, 1'b1, "extra_edge");
  endtask

  task automatic test_reset_mid_fill();
    int done_seen = 0;
    num_tiles = 4'd6;
    start     = 1'b1;
    @(posedge clk); #1; start = 1'b0;  // edge registered, CLEAR next
    @(posedge clk); #1;                // first FILL cycle
    @(posedge clk); #1;                // second FILL cycle
    reset = 1'b0;
    #1;
    n_checks++;
    if ({board, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL midfill_reset: got board=%h busy=%b done=%b want 0/0/0", board, busy, done);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy || board != '0) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) begin
      n_fail++;
      $display("FAIL midfill_after_release: got %0d active cycles want 0", done_seen);
    end
    @(posedge clk);
    #1;
    run_build(4'd4, 1, 1'b0, "after_reset");
  endtask

  task automatic test_hold_start();
    run_build(4'd5, 50, 1'b0, "start_held");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int gap = $urandom_range(0, 6);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
      end
      run_build(4'($urandom_range(0, 15)), $urandom_range(1, 3), 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_boundaries();
    test_ignore_start();
    test_reset_mid_fill();
    test_hold_start();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/board_generator.md
BOARD_GENERATOR -- requirements
Module: board_generator

Interface
REQ-001 Parameter: TILES, default 8, number of board tiles and the width of board.
REQ-002 Parameter: SEED, default 16'hACE1, LFSR value loaded at reset; SHALL be nonzero.
REQ-003 Port: clk  input  1  single system clock; all state SHALL change on posedge clk only.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  level request from the game controller; the block SHALL act on its rising edge only.
REQ-006 Port: num_tiles  input  4  target count of lit tiles; sampled on the start edge.
REQ-007 Port: board  output  TILES  solution board, one bit per tile, consumed by the datapath and the guess checker.
REQ-008 Port: busy  output  1  high while a board is being built.
REQ-009 Port: done  output  1  one-cycle pulse when board is complete and valid.

Function
REQ-010 A 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, SHALL advance every clk cycle in every state, and SHALL never hold zero.
REQ-011 The start edge SHALL be detected by a registered copy of start: edge = start & ~start_q.
REQ-012 States: IDLE, CLEAR, FILL, DONE; reset state IDLE.
REQ-013 IDLE: on edge -> CLEAR; latch target = clamp(num_tiles) where 0 maps to 1 and values >TILES map to TILES.
REQ-014 CLEAR: board <= 0, tile counter <= 0; next state FILL (exactly one cycle).
REQ-015 FILL: each cycle SHALL set exactly one currently-clear bit, chosen as the first clear index at or above p = lfsr[2:0], wrapping modulo TILES; counter += 1.
REQ-016 FILL SHALL exit to DONE in the cycle the counter reaches target; FILL lasts exactly target cycles.
REQ-017 DONE: done = 1 for that single cycle; next state IDLE.
REQ-018 busy SHALL be 1 in CLEAR and FILL, 0 in IDLE and DONE.
REQ-019 Latency: done SHALL assert 2 + target cycles after the cycle the start edge is registered.
REQ-020 board SHALL hold its value unchanged in IDLE and DONE until the next CLEAR.
REQ-021 Start edges while busy or in DONE SHALL be ignored and not queued; start held high SHALL NOT retrigger.
REQ-022 num_tiles changes after the start edge SHALL have no effect on the board in progress.
REQ-023 At completion, popcount(board) SHALL equal target exactly.
REQ-024 The tile counter SHALL be 4 bits wide, so counting to TILES=8 cannot overflow.

Reset
REQ-025 While reset = 0, all of the following SHALL hold asynchronously: state = IDLE, board = 0, busy = 0, done = 0, counter = 0, target = 1, start_q = 0, LFSR = SEED.
REQ-026 On reset during CLEAR or FILL, the board SHALL be abandoned with board = 0, and no done pulse SHALL follow release.
REQ-027 After reset is released, the first start edge SHALL be honoured normally.

Verification
REQ-028 Reset, then hold outputs -> board = 8'h00, busy = 0, done = 0, and the LFSR sequence from 16'hACE1 matches the reference model cycle for cycle.
REQ-029 num_tiles = 3, pulse start -> busy for 4 cycles, done pulse at edge+5, popcount(board) = 3, board equals the model prediction.
REQ-030 num_tiles = 0 -> popcount 1; num_tiles = 12 -> board = 8'hFF; num_tiles = 8 -> board = 8'hFF, done at edge+10.
REQ-031 Extra start edge during FILL, plus num_tiles changed mid-build -> single done pulse, popcount equals the originally latched target.
REQ-032 Assert reset during the 2nd FILL cycle -> board = 0 immediately, busy = 0, no done pulse; a subsequent start builds a correct board.
REQ-033 Hold start high for 50 cycles -> exactly one build, and board is stable after done.
